// File: rtl/mult_accum_ctrl.sv
// mult_accum_ctrl: sequencing and accumulate stage around a registered 4xN
// multiplier. Operand pairs are accepted over a valid/ready handshake and
// driven to the multiplier. After LAT settle cycles the product is added into
// a running sum. After TERMS products the sum is offered downstream.
// Optional feature macro: MAC_SATURATE_EN. When it is defined, the sum clamps
// at all ones instead of wrapping.
module mult_accum_ctrl #(
    parameter int N     = 4,
    parameter int LAT   = 2,
    parameter int TERMS = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_x,
    input  logic [N-1:0]     in_y,
    input  logic             clear,
    output logic [3:0]       mul_x,
    output logic [N-1:0]     mul_y,
    input  logic [N+3:0]     mul_res,
    output logic [ACC_W-1:0] acc,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [7:0]       term_cnt,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCUM, DONE} state_t;

    localparam logic [3:0] LAT_C   = 4'(LAT);
    localparam logic [7:0] TERMS_C = 8'(TERMS);

`ifdef MAC_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_t           state, state_nxt;
    logic [3:0]       wait_cnt;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_nxt;
    logic [7:0]       term_nxt;

    // Reduce the carry-extended sum to ACC_W bits: clamp to all ones when
    // saturation is built in, otherwise keep the wrapped low bits.
    function automatic logic [ACC_W-1:0] acc_limit(input logic [ACC_W:0] s);
        acc_limit = s[ACC_W-1:0] | {ACC_W{s[ACC_W] & SAT_EN}};
    endfunction

    assign sum_ext  = {1'b0, acc} + (ACC_W+1)'(mul_res);
    assign acc_nxt  = acc_limit(sum_ext);
    assign term_nxt = term_cnt + 8'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; clear overrides every transition.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        acc_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == 4'd1) state_nxt = ACCUM;
            end
            ACCUM: begin
                state_nxt = (term_nxt == TERMS_C) ? DONE : IDLE;
            end
            DONE: begin
                acc_valid = 1'b1;
                if (acc_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // Operand capture, settle counter and accumulator. clear zeroes the sum
    // and counters but leaves the operands on the multiplier untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_x    <= '0;
            mul_y    <= '0;
            acc      <= '0;
            term_cnt <= '0;
            overflow <= 1'b0;
            wait_cnt <= '0;
        end else if (clear) begin
            acc      <= '0;
            term_cnt <= '0;
            overflow <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mul_x    <= in_x;
                        mul_y    <= in_y;
                        wait_cnt <= LAT_C;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
                ACCUM: begin
                    acc      <= acc_nxt;
                    term_cnt <= term_nxt;
                    if (sum_ext[ACC_W]) overflow <= 1'b1;
                end
                DONE: begin
                    if (acc_ready) begin
                        acc      <= '0;
                        term_cnt <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_accum_ctrl.md
Name: mult_accum_ctrl

Overview:
- Sequencing and accumulate stage wrapped around the registered 4xN structural multiplier.
- Accepts operand pairs over a valid/ready handshake and drives them onto the multiplier inputs.
- Waits a fixed settle latency, captures the multiplier product, and adds it into a running sum.
- After TERMS products, presents the sum downstream with a valid/ready handshake (dot-product / MAC front end).

Parameters:
- N, 4, width of the y operand; must match the multiplier's N.
- LAT, 2, cycles from operand drive to a valid multiplier product (multiplier input register + output register); legal range 1..15.
- TERMS, 4, number of products summed per result; legal range 1..255.
- ACC_W, 12, accumulator width; must be at least N+4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept an operand pair.
- in_x  in  4  x operand.
- in_y  in  N  y operand.
- clear  in  1  synchronous abort: zero the sum, return to IDLE.
- mul_x  out  4  registered x to the multiplier.
- mul_y  out  N  registered y to the multiplier.
- mul_res  in  N+4  multiplier product.
- acc  out  ACC_W  running / final sum.
- acc_valid  out  1  final sum available.
- acc_ready  in  1  downstream takes the sum.
- term_cnt  out  8  products accumulated in the current result.
- overflow  out  1  sticky; a carry out of ACC_W occurred in the current result.

Behaviour:
- Reset (rst=1 at a rising edge, any state): state=IDLE; in_ready=1; mul_x=0; mul_y=0; acc=0; acc_valid=0; term_cnt=0; overflow=0; wait counter=0.
- FSM states: IDLE, WAIT, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: mul_x<=in_x, mul_y<=in_y, wait counter<=LAT, go to WAIT.
  - mul_x/mul_y hold their values until the next accept.
- WAIT:
  - in_ready=0; the counter decrements each cycle.
  - When the counter reaches 1, go to ACCUM. WAIT lasts exactly LAT cycles.
- ACCUM (1 cycle):
  - acc <= acc + zero-extend(mul_res); term_cnt <= term_cnt+1.
  - On carry out of bit ACC_W-1: overflow<=1; acc keeps the wrapped value.
  - If the new term_cnt equals TERMS, go to DONE; otherwise go to IDLE.
- Latency: an operand accepted at edge k is summed at edge k+LAT+1. Throughput is at most one term per LAT+2 cycles.
- DONE:
  - acc_valid=1, in_ready=0; acc, term_cnt and overflow are held stable.
  - On acc_ready=1: acc<=0, term_cnt<=0, overflow<=0, acc_valid<=0, go to IDLE.
  - acc_ready while not in DONE is ignored.
- clear=1 (any state): same effect as reset except mul_x/mul_y keep their values. clear has priority over every transition, including the DONE handshake. rst has priority over clear.
- Simultaneous in_valid and clear in IDLE: clear wins; the operand is not accepted.
- in_valid while in_ready=0: ignored. The sender must hold the operand until it sees in_ready=1.
- Product width: mul_res is N+4 bits and is added unsigned; the maximum single term is 15*(2^N-1).

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: in ACCUM, a sum exceeding 2^ACC_W-1 loads acc with all ones. Once saturated, acc stays at all ones for the rest of the result. overflow is still set.
- Not defined: the sum wraps modulo 2^ACC_W and overflow is set.

Test Plan:
- Basic sum (N=4, TERMS=4, ACC_W=12, LAT=2; multiplier model returns x*y LAT cycles after drive):
  - Send (3,5),(15,15),(7,2),(0,9).
  - Expect term_cnt steps 1..4; acc_valid=1 with acc=254 and overflow=0; in_ready returns 1 one cycle after acc_ready.
- Latency:
  - Accept (2,3) at edge k.
  - Expect acc=6 exactly at edge k+3; in_ready low for edges k+1..k+3 and high again after edge k+3.
- Backpressure:
  - Complete a result of 12, hold acc_ready=0 for 5 cycles while in_valid=1.
  - Expect acc=12 and acc_valid=1 held; in_ready=0; no operand accepted; sum cleared in the cycle after acc_ready=1.
- Overflow (ACC_W=8, TERMS=2):
  - Send (15,15),(15,15).
  - Without MAC_SATURATE_EN: acc=194, overflow=1.
  - With MAC_SATURATE_EN: acc=255, overflow=1.
- Clear mid-WAIT:
  - After terms (4,4),(5,5) sum to 41, accept (6,6) and assert clear during WAIT.
  - Expect next cycle: state IDLE, acc=0, term_cnt=0, in_ready=1; the 36 product is never added.
- Reset mid-DONE:
  - Assert rst while acc_valid=1.
  - Expect all outputs at reset values at the next edge; a fresh 4-term sequence then sums correctly.
